// File: rtl/id_ex_register.sv
// ID/EX pipeline register: two-entry skid buffer with a registered ready, a stall counter and
// optional writeback bypass of captured and held operands (enable with ID_EX_BYPASS_EN).
module id_ex_register (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic [31:0] imm,
  input  logic [15:0] ctrl,
  input  logic        wb_regWrite,
  input  logic [4:0]  wb_writeRegister,
  input  logic [31:0] wb_writeData,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_imm,
  output logic [15:0] out_ctrl,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [15:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] stall_q, stall_d;

  entry_t      in_entry, head_cur, skid_cur;
  logic        accept, deliver;

`ifdef ID_EX_BYPASS_EN
  // A nonzero write address never matches index 0, so zeroed operands stay zero.
  function automatic entry_t bypass(entry_t e, logic we, logic [4:0] wa, logic [31:0] wd);
    entry_t r;
    r = e;
    if (we && (wa != 5'd0)) begin
      if (e.rs == wa) r.data1 = wd;
      if (e.rt == wa) r.data2 = wd;
    end
    return r;
  endfunction
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regWrite, wb_writeRegister, wb_writeData};
`endif

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  always_comb begin
    in_entry.rs    = rs;
    in_entry.rt    = rt;
    in_entry.rd    = rd;
    in_entry.data1 = (rs == 5'd0) ? 32'd0 : readData1;
    in_entry.data2 = (rt == 5'd0) ? 32'd0 : readData2;
    in_entry.imm   = imm;
    in_entry.ctrl  = ctrl;
    head_cur       = head_q;
    skid_cur       = skid_q;
`ifdef ID_EX_BYPASS_EN
    in_entry = bypass(in_entry, wb_regWrite, wb_writeRegister, wb_writeData);
    head_cur = bypass(head_q, wb_regWrite, wb_writeRegister, wb_writeData);
    skid_cur = bypass(skid_q, wb_regWrite, wb_writeRegister, wb_writeData);
`endif
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_cur;
    skid_d  = skid_cur;
    if (flush) begin
      state_d = StEmpty;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && !deliver) begin
            skid_d  = in_entry;
            state_d = StTwo;
          end else if (accept && deliver) begin
            head_d  = in_entry;
          end else if (deliver) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (deliver) begin
            head_d  = skid_cur;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d  = (state_d != StTwo);
    out_valid_d = (state_d != StEmpty);
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_rs      = head_q.rs;
  assign out_rt      = head_q.rt;
  assign out_rd      = head_q.rd;
  assign out_data1   = head_q.data1;
  assign out_data2   = head_q.data2;
  assign out_imm     = head_q.imm;
  assign out_ctrl    = head_q.ctrl;
  assign stall_count = stall_q;

endmodule
